// File: rtl/avg_pkg.sv
// Shared types and default geometry for the averaged-frame SRAM reader.
package avg_pkg;
  localparam int DEF_COLS   = 640;
  localparam int DEF_ROWS   = 480;
  localparam int DEF_ADDR_W = 20;
  localparam int DATA_W     = 16;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;
endpackage

// File: rtl/avg_skid_fifo.sv
// Two-entry FIFO holding pixel payloads between the SRAM read pipe and the
// valid/ready output; entry "head" is always the oldest word.
module avg_skid_fifo #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic [1:0]   count
);
  logic [W-1:0] tail;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      count <= '0;
    end else if (pop && count != 2'd0) begin
      if (push) begin
        if (count == 2'd2) begin
          head <= tail;
          tail <= din;
        end else begin
          head <= din;
        end
      end else begin
        head  <= tail;
        count <= count - 2'd1;
      end
    end else if (push && count != 2'd2) begin
      if (count == 2'd0) head <= din;
      else               tail <= din;
      count <= count + 2'd1;
    end
  end
endmodule

// File: rtl/avg_sram_reader.sv
// Scans one frame of averaged words out of SRAM (py inner, px outer) and streams
// them over valid/ready. Build option AVG_READER_MASK_EN adds i_thresh/o_mask.
//
// state   | meaning
// S_IDLE  | waiting for i_start
// S_READ  | issuing reads, throttled so FIFO + in-flight never exceeds 2
// S_DRAIN | all reads issued, waiting for the last pixel handshake
module avg_sram_reader
  import avg_pkg::*;
#(
  parameter int COLS   = DEF_COLS,
  parameter int ROWS   = DEF_ROWS,
  parameter int ADDR_W = DEF_ADDR_W,
  localparam int PX_W  = $clog2(COLS),
  localparam int PY_W  = $clog2(ROWS)
) (
  input  logic              i_50M_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_stop,
  input  logic [DATA_W-1:0] i_sram_data_read,
  output logic [ADDR_W-1:0] o_SRAM_addr,
  output logic              o_sram_rd,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_data,
  output logic [PX_W-1:0]   o_px,
  output logic [PY_W-1:0]   o_py,
  output logic              o_busy,
  output logic              o_frame_done
`ifdef AVG_READER_MASK_EN
  ,
  input  logic [DATA_W-1:0] i_thresh,
  output logic              o_mask
`endif
);
  localparam logic [PX_W-1:0] PX_LAST = PX_W'(COLS - 1);
  localparam logic [PY_W-1:0] PY_LAST = PY_W'(ROWS - 1);
`ifdef AVG_READER_MASK_EN
  localparam int PL_W = DATA_W + PX_W + PY_W + 1;
`else
  localparam int PL_W = DATA_W + PX_W + PY_W;
`endif

  state_t            state;
  logic [PX_W-1:0]   px_q, rd_px;
  logic [PY_W-1:0]   py_q, rd_py;
  logic [1:0]        fifo_count;
  logic [2:0]        count_after;
  logic              handshake, can_issue, head_last;
  logic [ADDR_W-1:0] addr_calc;
  logic [PL_W-1:0]   push_word, head_word;

  // The word arriving this cycle belongs to the read issued last cycle.
`ifdef AVG_READER_MASK_EN
  assign push_word = {i_sram_data_read > i_thresh, rd_px, rd_py, i_sram_data_read};
  assign {o_mask, o_px, o_py, o_data} = head_word;
`else
  assign push_word = {rd_px, rd_py, i_sram_data_read};
  assign {o_px, o_py, o_data} = head_word;
`endif

  avg_skid_fifo #(.W(PL_W)) u_fifo (
    .clk   (i_50M_clk),
    .rst_n (i_rst_n),
    .flush (i_stop),
    .push  (o_sram_rd),
    .din   (push_word),
    .pop   (handshake),
    .head  (head_word),
    .count (fifo_count)
  );

  assign o_valid   = (fifo_count != 2'd0);
  assign handshake = o_valid && i_ready;
  assign o_busy    = (state != S_IDLE);
  assign head_last = (o_px == PX_LAST) && (o_py == PY_LAST);

  // Occupancy after this edge; a new read is allowed if it leaves room for its data.
  assign count_after = 3'(fifo_count) + 3'(o_sram_rd) - 3'(handshake);
  assign can_issue   = (count_after < 3'd2);
  assign addr_calc   = ADDR_W'(COLS) * ADDR_W'(px_q) + ADDR_W'(py_q);

  assign o_frame_done = i_rst_n && !i_stop && (state == S_DRAIN) && handshake && head_last;

  always_ff @(posedge i_50M_clk) begin
    if (!i_rst_n) begin
      state       <= S_IDLE;
      px_q        <= '0;
      py_q        <= '0;
      rd_px       <= '0;
      rd_py       <= '0;
      o_sram_rd   <= 1'b0;
      o_SRAM_addr <= '0;
    end else if (i_stop) begin
      state       <= S_IDLE;
      px_q        <= '0;
      py_q        <= '0;
      o_sram_rd   <= 1'b0;
      o_SRAM_addr <= '0;
    end else begin
      o_sram_rd   <= 1'b0;
      o_SRAM_addr <= '0;
      case (state)
        S_IDLE: begin
          if (i_start) begin
            px_q  <= '0;
            py_q  <= '0;
            state <= S_READ;
          end
        end
        S_READ: begin
          if (can_issue) begin
            o_sram_rd   <= 1'b1;
            o_SRAM_addr <= addr_calc;
            rd_px       <= px_q;
            rd_py       <= py_q;
            if (py_q == PY_LAST) begin
              py_q <= '0;
              px_q <= px_q + PX_W'(1);
            end else begin
              py_q <= py_q + PY_W'(1);
            end
            if (px_q == PX_LAST && py_q == PY_LAST) state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (handshake && head_last) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_avg_sram_reader.sv
// Bench for avg_sram_reader on a small 8x6 frame; pixel-stream model plus directed
// scenarios for start latency, backpressure, stop, start/stop collision and reset.
module tb_avg_sram_reader;
  localparam int COLS   = 8;
  localparam int ROWS   = 6;
  localparam int ADDR_W = 20;
  localparam int N      = COLS * ROWS;
  localparam int PX_W   = $clog2(COLS);
  localparam int PY_W   = $clog2(ROWS);

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              stop = 1'b0;
  logic              ready = 1'b0;
  logic [15:0]       data_off = 16'h0000;
  logic [15:0]       sram_data;
  logic [ADDR_W-1:0] addr;
  logic              rd, o_valid, busy, frame_done;
  logic [15:0]       o_data;
  logic [PX_W-1:0]   o_px;
  logic [PY_W-1:0]   o_py;
`ifdef AVG_READER_MASK_EN
  logic [15:0]       thresh = 16'h0100;
  logic              mask;
  logic              m_seen [3];
`endif

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  // SRAM model: word at an address is the address itself (plus an optional offset).
  assign sram_data = addr[15:0] + data_off;

  avg_sram_reader #(.COLS(COLS), .ROWS(ROWS), .ADDR_W(ADDR_W)) dut (
    .i_50M_clk        (clk),
    .i_rst_n          (rst_n),
    .i_start          (start),
    .i_stop           (stop),
    .i_sram_data_read (sram_data),
    .o_SRAM_addr      (addr),
    .o_sram_rd        (rd),
    .o_valid          (o_valid),
    .i_ready          (ready),
    .o_data           (o_data),
    .o_px             (o_px),
    .o_py             (o_py),
    .o_busy           (busy),
    .o_frame_done     (frame_done)
`ifdef AVG_READER_MASK_EN
    ,
    .i_thresh         (thresh),
    .o_mask           (mask)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int exp_px(input int n);
    return n / ROWS;
  endfunction
  function automatic int exp_py(input int n);
    return n % ROWS;
  endfunction
  function automatic int exp_addr(input int n);
    return COLS * exp_px(n) + exp_py(n);
  endfunction
  function automatic logic [15:0] exp_word(input int n);
    logic [15:0] a;
    a = 16'(exp_addr(n));
    return a + data_off;
  endfunction

  // Model state: pixels delivered and reads issued since the current frame began.
  int               exp_idx = 0;
  int               issued = 0;
  int               done_cnt = 0;
  int               idx0;
  logic             hs, exp_done;
  logic             pv = 1'b0, pr = 1'b0;
  logic [15:0]      pd;
  logic [PX_W-1:0]  ppx;
  logic [PY_W-1:0]  ppy;
  logic [15:0]      seen_12 = 16'hFFFF, seen_last = 16'hFFFF;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_idx = 0;
      issued  = 0;
      pv      = 1'b0;
    end else begin
      idx0 = exp_idx;
      hs   = o_valid && ready;
      if (pv && !pr) begin
        check("hold_valid", o_valid, 1);
        check("hold_data", o_data, pd);
        check("hold_px", o_px, ppx);
        check("hold_py", o_py, ppy);
      end
      if (o_valid) begin
        if (idx0 < N) begin
          check("pix_px", o_px, exp_px(idx0));
          check("pix_py", o_py, exp_py(idx0));
          check("pix_data", o_data, exp_word(idx0));
`ifdef AVG_READER_MASK_EN
          check("pix_mask", mask, exp_word(idx0) > thresh);
`endif
        end else begin
          check("pix_extra", idx0, N - 1);
        end
      end
      exp_done = hs && (idx0 == N - 1) && !stop;
      check("frame_done", frame_done, exp_done);
      if (frame_done) done_cnt++;
      if (rd) begin
        check("rd_window", (issued - idx0) <= 1, 1);
        if (issued < N) check("rd_addr", addr, exp_addr(issued));
        else            check("rd_extra", issued, N - 1);
        issued++;
      end else begin
        check("addr_idle", addr, 0);
      end
      if (hs) begin
        if (o_px == 1 && o_py == 2) seen_12 = o_data;
        if (o_px == PX_W'(COLS - 1) && o_py == PY_W'(ROWS - 1)) seen_last = o_data;
`ifdef AVG_READER_MASK_EN
        if (idx0 < 3) m_seen[idx0] = mask;
`endif
        exp_idx++;
      end
      pv  = o_valid;
      pr  = ready;
      pd  = o_data;
      ppx = o_px;
      ppy = o_py;
      if (stop || (start && !busy)) begin
        exp_idx = 0;
        issued  = 0;
        pv      = 1'b0;
      end
    end
  end

  task automatic start_frame();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int d0;
    d0 = done_cnt;
    for (int i = 0; i < budget && done_cnt == d0; i++) @(posedge clk);
    check(name, done_cnt, d0 + 1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, o_valid, 0);
    check({tag, "_rd"}, rd, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, frame_done, 0);
    check({tag, "_addr"}, addr, 0);
    check({tag, "_data"}, o_data, 0);
    check({tag, "_px"}, o_px, 0);
    check({tag, "_py"}, o_py, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all_zero("rst");
    @(posedge clk); #1 rst_n = 1'b1;

    // Full frame, ready held high: 2-cycle latency then one pixel per cycle
    ready = 1'b1;
    d0 = done_cnt;
    start_frame();
    @(negedge clk);
    check("lat_busy", busy, 1);
    check("lat_valid0", o_valid, 0);
    @(negedge clk);
    check("lat_valid1", o_valid, 0);
    check("lat_rd", rd, 1);
    @(negedge clk);
    check("lat_valid2", o_valid, 1);
    check("lat_px", o_px, 0);
    check("lat_py", o_py, 0);
    repeat (N - 1) @(negedge clk);
    check("stream_done", frame_done, 1);
    @(negedge clk);
    check("after_busy", busy, 0);
    check("after_valid", o_valid, 0);
    @(posedge clk);
    check("frame1_count", done_cnt, d0 + 1);
    check("frame1_pixels", exp_idx, N);
    check("pin_px1_py2", seen_12, 16'd10);
    check("pin_last", seen_last, 16'd61);

    // Random backpressure
    d0 = done_cnt;
    start_frame();
    for (int i = 0; i < 1000 && done_cnt == d0; i++) begin
      @(posedge clk); #1 ready = 1'($urandom_range(0, 1));
    end
    check("rand_done", done_cnt, d0 + 1);
    check("rand_pixels", exp_idx, N);
    ready = 1'b1;
    @(negedge clk);
    check("rand_busy", busy, 0);

    // Stop mid-frame, then restart from pixel 0
    d0 = done_cnt;
    start_frame();
    for (int i = 0; i < 100 && exp_idx < 10; i++) @(posedge clk);
    check("stop_reached", exp_idx >= 10, 1);
    #1 stop = 1'b1;
    @(posedge clk); #1 stop = 1'b0;
    @(negedge clk);
    check("stop_valid", o_valid, 0);
    check("stop_rd", rd, 0);
    check("stop_busy", busy, 0);
    repeat (3) @(negedge clk);
    check("stop_quiet", o_valid, 0);
    check("stop_no_done", done_cnt, d0);
    start_frame();
    repeat (3) @(negedge clk);
    check("restart_valid", o_valid, 1);
    check("restart_px", o_px, 0);
    check("restart_py", o_py, 0);
    wait_done("restart_done", 200);

    // Start and stop together while idle
    @(posedge clk); #1 begin start = 1'b1; stop = 1'b1; end
    @(posedge clk); #1 begin start = 1'b0; stop = 1'b0; end
    @(negedge clk);
    check("collide_busy", busy, 0);
    check("collide_rd", rd, 0);
    @(negedge clk);
    check("collide_busy2", busy, 0);
    check("collide_valid", o_valid, 0);

    // Reset for one cycle mid-frame
    start_frame();
    for (int i = 0; i < 200 && exp_idx < 15; i++) begin
      @(posedge clk); #1 ready = 1'($urandom_range(0, 1));
    end
    check("rst_reached", exp_idx >= 15, 1);
    #1 rst_n = 1'b0;
    @(posedge clk); #1 begin rst_n = 1'b1; ready = 1'b1; end
    @(negedge clk);
    check_all_zero("midrst");
    d0 = done_cnt;
    start_frame();
    wait_done("postrst_done", 200);

`ifdef AVG_READER_MASK_EN
    // Threshold compare around 0x0100
    data_off = 16'h00FF;
    start_frame();
    wait_done("mask_done", 200);
    check("mask_00ff", m_seen[0], 0);
    check("mask_0100", m_seen[1], 0);
    check("mask_0101", m_seen[2], 1);
    data_off = 16'h0000;
`endif

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
